// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram_arb_pkg;

  typedef enum logic {
    StServe = 1'b0,
    StClear = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned P_FETCH   = 0;
  localparam int unsigned P_LSU     = 1;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle: two request/grant ports plus the shared read-data return.
interface bram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;

  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a one-bit priority pointer; grants only while en_i is high.
module rr_arbiter2
  import bram_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o[P_FETCH] = 1'b1;
        2'b10:   gnt_o[P_LSU]   = 1'b1;
        2'b11:   gnt_o[rr_ptr_q] = 1'b1;
        default: gnt_o = '0;
      endcase
    end

    // Priority passes to whichever port lost (or did not ask) this cycle.
    rr_ptr_d = rr_ptr_q;
    if (gnt_o[P_FETCH]) begin
      rr_ptr_d = 1'(P_LSU);
    end else if (gnt_o[P_LSU]) begin
      rr_ptr_d = 1'(P_FETCH);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'(P_FETCH);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM between fetch and load/store requesters, with a runtime zero-fill sweep.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  bram_port_arbiter_if.slave    bus_io,
  input  logic                  clear_start_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic                  bram_re_o,
  output logic [ADDR_WIDTH-1:0] bram_raddr_o,
  output logic                  bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_waddr_o,
  output logic [DATA_WIDTH-1:0] bram_wdata_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i
);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic                  arb_en;
  logic [NUM_PORTS-1:0]  req, gnt;

  assign req = {bus_io.req1, bus_io.req0};
  // A clear request wins over any pending request in the same cycle.
  assign arb_en = (state_q == StServe) && !clear_start_i;

  rr_arbiter2 u_rr_arbiter2 (
    .clock (clock),
    .reset (reset),
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    bram_re_o    = 1'b0;
    bram_raddr_o = '0;
    bram_we_o    = 1'b0;
    bram_waddr_o = '0;
    bram_wdata_o = '0;

    unique case (state_q)
      StServe: begin
        if (clear_start_i) begin
          state_d = StClear;
        end
        if (gnt[P_FETCH]) begin
          if (bus_io.we0) begin
            bram_we_o    = 1'b1;
            bram_waddr_o = bus_io.addr0;
            bram_wdata_o = bus_io.wdata0;
          end else begin
            bram_re_o    = 1'b1;
            bram_raddr_o = bus_io.addr0;
          end
        end else if (gnt[P_LSU]) begin
          if (bus_io.we1) begin
            bram_we_o    = 1'b1;
            bram_waddr_o = bus_io.addr1;
            bram_wdata_o = bus_io.wdata1;
          end else begin
            bram_re_o    = 1'b1;
            bram_raddr_o = bus_io.addr1;
          end
        end
      end
      StClear: begin
        bram_we_o    = 1'b1;
        bram_waddr_o = cnt_q;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = StServe;
          done_d  = 1'b1;
        end
      end
      default: state_d = StServe;
    endcase
  end

  // Read tags line up with the BRAM's one-cycle registered read data.
  assign rvalid_d = gnt & ~{bus_io.we1, bus_io.we0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StServe;
      cnt_q    <= '0;
      rvalid_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.gnt0    = gnt[P_FETCH];
  assign bus_io.gnt1    = gnt[P_LSU];
  assign bus_io.rvalid0 = rvalid_q[P_FETCH];
  assign bus_io.rvalid1 = rvalid_q[P_LSU];
  assign bus_io.rdata   = bram_rdata_i;
  assign clear_busy_o   = (state_q == StClear);
  assign clear_done_o   = done_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: behavioural BRAM, read-data scoreboard, one task per scenario.
module tb_bram_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus_io        (bus),
    .clear_start_i (clear_start),
    .clear_busy_o  (clear_busy),
    .clear_done_o  (clear_done),
    .bram_re_o     (bram_re),
    .bram_raddr_o  (bram_raddr),
    .bram_we_o     (bram_we),
    .bram_waddr_o  (bram_waddr),
    .bram_wdata_o  (bram_wdata),
    .bram_rdata_i  (bram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural BRAM with a side-door preload port.
  logic [DW-1:0] mem [DEPTH];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clock) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    if (bram_re) bram_rdata <= (bram_we && bram_waddr == bram_raddr) ? bram_wdata : mem[bram_raddr];
  end

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_exp;
  logic [DW-1:0] ref_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;

  // Scoreboard consumer: every rvalid must match the oldest expected read.
  always @(negedge clock) begin
    if (!reset && (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: rvalid0=%b rvalid1=%b, required no response",
                 bus.rvalid0, bus.rvalid1);
      end else begin
        mon_exp = sb_q.pop_front();
        if ((bus.rvalid0 === 1'b1 && bus.rvalid1 === 1'b1) || bus.rvalid1 !== mon_exp.port ||
            bus.rdata !== mon_exp.data) begin
          errors++;
          $display("FAIL read_return: port=%b rdata=%h, required port=%b rdata=%h",
                   bus.rvalid1, bus.rdata, mon_exp.port, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    clear_start = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clock);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, clear_busy, clear_done, bram_re, bram_we}
        !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, clear_busy, clear_done, bram_re,
                bram_we});
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, clear_busy, clear_done, bram_re, bram_we}
        !== 8'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, required 00000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, clear_busy, clear_done, bram_re,
                bram_we});
    end
    tick();
  endtask

  task automatic test_read_single();
    preload(8'h10, 32'hDEADBEEF);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
    @(negedge clock);
    checks++;
    if ({bus.gnt0, bus.gnt1, bram_re, bram_we} !== 4'b1010 || bram_raddr !== 8'h10) begin
      errors++;
      $display("FAIL single_read_grant: gnt0/gnt1/re/we=%b raddr=%h, required 1010 raddr=10",
               {bus.gnt0, bus.gnt1, bram_re, bram_we}, bram_raddr);
    end
    sb_q.push_back('{port: 1'b0, data: ref_mem[8'h10]});
    tick();
    bus.req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_read_rvalid: rvalid0=%b rvalid1=%b, required 1 0",
               bus.rvalid0, bus.rvalid1);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_read_rvalid_drop: rvalid0=%b, required 0", bus.rvalid0);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]    exp_gnt;
    logic [AW-1:0] exp_addr;
    reset_pulse();
    preload(8'h01, 32'hA1A1_0001);
    preload(8'h02, 32'hB2B2_0002);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
    for (int i = 0; i < 4; i++) begin
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 8'h01 : 8'h02;
      @(negedge clock);
      checks++;
      if ({bus.gnt1, bus.gnt0} !== exp_gnt || bram_re !== 1'b1 || bram_raddr !== exp_addr) begin
        errors++;
        $display("FAIL contention_grant[%0d]: gnt1gnt0=%b re=%b raddr=%h, required %b 1 %h",
                 i, {bus.gnt1, bus.gnt0}, bram_re, bram_raddr, exp_gnt, exp_addr);
      end
      sb_q.push_back('{port: exp_gnt[1], data: ref_mem[exp_addr]});
      tick();
    end
    idle_inputs();
    tick();
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL contention_drain: %0d reads outstanding, required 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_write_then_read();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'hA0; bus.wdata1 = 32'h12345678;
    @(negedge clock);
    checks++;
    if ({bus.gnt1, bus.gnt0, bram_we, bram_re} !== 4'b1010 || bram_waddr !== 8'hA0 ||
        bram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL write_drive: gnt1/gnt0/we/re=%b waddr=%h wdata=%h, required 1010 a0 12345678",
               {bus.gnt1, bus.gnt0, bram_we, bram_re}, bram_waddr, bram_wdata);
    end
    ref_mem[8'hA0] = 32'h12345678;
    tick();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hA0;
    @(negedge clock);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bram_re !== 1'b1) begin
      errors++;
      $display("FAIL write_no_rvalid: gnt0=%b rvalid1=%b re=%b, required 1 0 1",
               bus.gnt0, bus.rvalid1, bram_re);
    end
    sb_q.push_back('{port: 1'b0, data: ref_mem[8'hA0]});
    tick();
    bus.req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL write_read_rvalid: rvalid0=%b, required 1", bus.rvalid0);
    end
    tick();
  endtask

  task automatic test_clear();
    preload(8'h10, 32'h5A5A5A5A);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
    clear_start = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.gnt0, bus.gnt1, bram_re, bram_we, clear_busy} !== 5'b0) begin
      errors++;
      $display("FAIL clear_start_priority: gnt0/gnt1/re/we/busy=%b, required 00000",
               {bus.gnt0, bus.gnt1, bram_re, bram_we, clear_busy});
    end
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      checks++;
      if (clear_busy !== 1'b1 || bus.gnt0 !== 1'b0 || bram_we !== 1'b1 || bram_re !== 1'b0 ||
          bram_waddr !== AW'(i) || bram_wdata !== '0 || clear_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_sweep[%0d]: busy=%b gnt0=%b we=%b re=%b waddr=%h wdata=%h done=%b",
                 i, clear_busy, bus.gnt0, bram_we, bram_re, bram_waddr, bram_wdata, clear_done);
      end
      tick();
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    @(negedge clock);
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0 || bus.gnt0 !== 1'b1 || bram_raddr !== 8'h10)
    begin
      errors++;
      $display("FAIL clear_done: done=%b busy=%b gnt0=%b raddr=%h, required 1 0 1 10",
               clear_done, clear_busy, bus.gnt0, bram_raddr);
    end
    sb_q.push_back('{port: 1'b0, data: ref_mem[8'h10]});
    tick();
    bus.req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (clear_done !== 1'b0 || bus.rvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_done_pulse: done=%b rvalid0=%b, required 0 1", clear_done, bus.rvalid0);
    end
    tick();
  endtask

  task automatic test_inflight_clear();
    int  cyc;
    logic seen;
    preload(8'h33, 32'h0BADCAFE);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h33;
    @(negedge clock);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL inflight_grant: gnt0=%b, required 1", bus.gnt0);
    end
    sb_q.push_back('{port: 1'b0, data: ref_mem[8'h33]});
    tick();
    bus.req0 = 1'b0;
    clear_start = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.gnt0 !== 1'b0 || bram_we !== 1'b0) begin
      errors++;
      $display("FAIL inflight_rvalid: rvalid0=%b gnt0=%b we=%b, required 1 0 0",
               bus.rvalid0, bus.gnt0, bram_we);
    end
    tick();
    clear_start = 1'b0;
    @(negedge clock);
    checks++;
    if (clear_busy !== 1'b1 || bram_we !== 1'b1 || bram_waddr !== 8'h00 || bus.rvalid0 !== 1'b0)
    begin
      errors++;
      $display("FAIL inflight_sweep_start: busy=%b we=%b waddr=%h rvalid0=%b, required 1 1 00 0",
               clear_busy, bram_we, bram_waddr, bus.rvalid0);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    cyc  = 1;
    seen = 1'b0;
    // A clear_start in mid-sweep must not restart the counter.
    for (int k = 0; k < 300 && !seen; k++) begin
      clear_start = (cyc == 100);
      tick();
      @(negedge clock);
      cyc++;
      if (clear_done === 1'b1) seen = 1'b1;
    end
    clear_start = 1'b0;
    checks++;
    if (!seen || cyc != DEPTH + 1) begin
      errors++;
      $display("FAIL clear_length: done seen=%b at cycle %0d, required 1 at %0d",
               seen, cyc, DEPTH + 1);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    logic found;
    preload(8'h80, 32'hCAFEF00D);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clock);
      if (clear_busy === 1'b1 && bram_waddr === 8'h40) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midclear_reach: sweep address 40 not seen, required seen");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || bram_we !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL midclear_abort: busy=%b we=%b done=%b, required 0 0 0",
               clear_busy, bram_we, clear_done);
    end
    for (int a = 0; a < 8'h40; a++) ref_mem[a] = '0;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      checks++;
      if (clear_done !== 1'b0 || clear_busy !== 1'b0) begin
        errors++;
        $display("FAIL midclear_no_done[%0d]: done=%b busy=%b, required 0 0",
                 j, clear_done, clear_busy);
      end
      tick();
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h80;
    @(negedge clock);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL midclear_read_grant: gnt0=%b, required 1", bus.gnt0);
    end
    sb_q.push_back('{port: 1'b0, data: ref_mem[8'h80]});
    tick();
    bus.req0 = 1'b0;
    @(negedge clock);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_single();
    test_contention();
    test_write_then_read();
    test_clear();
    test_inflight_clear();
    test_reset_mid_clear();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d reads never returned, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
